// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared types and helpers for the channel delay line
package delay_line_pkg;

    // Config fields are carried at a fixed generous width and narrowed at the point of use
    localparam int CFG_FW = 8;

    typedef enum logic {
        IDLE,
        BLANK
    } state_t;

    typedef struct packed {
        logic [CFG_FW-1:0] chan;
        logic [CFG_FW-1:0] delay;
        logic [CFG_FW-1:0] width;
    } cfg_t;

    function automatic int cbits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/channel_delay_tap.sv
// rtl/channel_delay_tap.sv - one channel: shift register, tap mux, pulse stretcher and blank mask
module channel_delay_tap
    import delay_line_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DBITS = 4,
    parameter int WBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chan_in,
    input  logic [DBITS-1:0] delay,
    input  logic [WBITS-1:0] width,
    input  logic             kill,
    output logic             dout
);

    logic [DEPTH-1:0] sr_q, sr_d;
    logic [WBITS-1:0] cnt_q, cnt_d;
    logic             tap_prev_q, tap_prev_d;
    logic             out_q, out_d;
    logic             tap;

    always_comb begin
        sr_d       = {sr_q[DEPTH-2:0], chan_in};
        tap        = (delay == '0) ? chan_in : sr_q[delay - DBITS'(1)];
        tap_prev_d = tap;
        cnt_d      = '0;
        out_d      = 1'b0;
        // kill holds the output and stretch counter at zero while the pipeline refills
        if (!kill) begin
            if (width == '0) begin
                out_d = tap;
            end else begin
                if (tap && !tap_prev_q) begin
                    cnt_d = width;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WBITS'(1);
                end
                out_d = (cnt_d != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            tap_prev_q <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tap_prev_q <= tap_prev_d;
            out_q      <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/channel_delay_line.sv
// rtl/channel_delay_line.sv - per-channel programmable delay/stretch with config FSM and blanking
module channel_delay_line
    import delay_line_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int DEPTH = 16,
    parameter int WBITS = 4,
    parameter int DBITS = $clog2(DEPTH),
    parameter int CBITS = cbits_for(NCHAN)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NCHAN-1:0] Channels,
    input  logic             CfgValid,
    output logic             CfgReady,
    input  logic [CBITS-1:0] CfgChan,
    input  logic [DBITS-1:0] CfgDelay,
    input  logic [WBITS-1:0] CfgWidth,
    output logic [NCHAN-1:0] DlayChann,
    output logic             Busy
);

    localparam int BCW = $clog2(DEPTH) + 1;

    state_t                      state_q, state_d;
    logic [BCW-1:0]              bcnt_q, bcnt_d;
    logic [CBITS-1:0]            bchan_q, bchan_d;
    logic [NCHAN-1:0][DBITS-1:0] delay_q, delay_d;
    logic [NCHAN-1:0][WBITS-1:0] width_q, width_d;
    logic [NCHAN-1:0]            kill;
    cfg_t                        req;
    logic                        wr;

    always_comb begin
        req = '{chan: CFG_FW'(CfgChan), delay: CFG_FW'(CfgDelay), width: CFG_FW'(CfgWidth)};
        // out-of-range requests still complete the handshake but touch nothing
        wr      = CfgValid && (state_q == IDLE) && (req.chan < CFG_FW'(NCHAN));
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bchan_d = bchan_q;
        delay_d = delay_q;
        width_d = width_q;
        kill    = '0;
        case (state_q)
            IDLE: begin
                if (wr) begin
                    state_d = BLANK;
                    bcnt_d  = BCW'(DEPTH);
                    bchan_d = CBITS'(req.chan);
                end
            end
            BLANK: begin
                bcnt_d = bcnt_q - BCW'(1);
                if (bcnt_q == BCW'(1)) begin
                    state_d = IDLE;
                end
            end
        endcase
        for (int i = 0; i < NCHAN; i++) begin
            if (wr && (req.chan == CFG_FW'(i))) begin
                delay_d[i] = DBITS'(req.delay);
                width_d[i] = WBITS'(req.width);
                kill[i]    = 1'b1;
            end
            if ((state_q == BLANK) && (bchan_q == CBITS'(i))) begin
                kill[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bchan_q <= '0;
            delay_q <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bchan_q <= bchan_d;
            delay_q <= delay_d;
            width_q <= width_d;
        end
    end

    assign CfgReady = (state_q == IDLE);
    assign Busy     = (state_q == BLANK);

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        channel_delay_tap #(
            .DEPTH(DEPTH),
            .DBITS(DBITS),
            .WBITS(WBITS)
        ) u_tap (
            .clk    (Clk),
            .rst    (Rst),
            .chan_in(Channels[g]),
            .delay  (delay_q[g]),
            .width  (width_q[g]),
            .kill   (kill[g]),
            .dout   (DlayChann[g])
        );
    end

endmodule

// File: tb/tb_channel_delay_line.sv
// tb/tb_channel_delay_line.sv - randomized and directed bench against a behavioural delay-line model
module tb_channel_delay_line;

    localparam int NCH   = 5;
    localparam int DEPTH = 16;
    localparam int WB    = 4;
    localparam int DB    = 4;
    localparam int CB    = 3;
    localparam int MAXT  = 8192;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [NCH-1:0] Channels;
    logic           CfgValid;
    logic           CfgReady;
    logic [CB-1:0]  CfgChan;
    logic [DB-1:0]  CfgDelay;
    logic [WB-1:0]  CfgWidth;
    logic [NCH-1:0] DlayChann;
    logic           Busy;

    channel_delay_line #(
        .NCHAN(NCH),
        .DEPTH(DEPTH),
        .WBITS(WB)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Channels (Channels),
        .CfgValid (CfgValid),
        .CfgReady (CfgReady),
        .CfgChan  (CfgChan),
        .CfgDelay (CfgDelay),
        .CfgWidth (CfgWidth),
        .DlayChann(DlayChann),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    // model: input history, per-channel config, time of last accepted rise, blanking window
    bit hist [NCH][MAXT];
    int m_delay [NCH];
    int m_width [NCH];
    int last_rise [NCH];
    bit tprev [NCH];
    int ta;
    int bchan;
    bit rand_hits = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, t);
        end
    endtask

    function automatic bit exp_busy(input int tt);
        return (tt > ta) && (tt <= ta + DEPTH);
    endfunction

    function automatic bit m_tap(input int i);
        if (m_delay[i] == 0) return Channels[i];
        if (t - m_delay[i] < 0) return 1'b0;
        return hist[i][t - m_delay[i]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_delay[i]   = 0;
            m_width[i]   = 0;
            last_rise[i] = -1000;
            tprev[i]     = 1'b0;
            for (int k = 0; k < MAXT; k++) hist[i][k] = 1'b0;
        end
        ta    = -1000;
        bchan = 0;
    endtask

    // one clock: predict the next outputs from the applied inputs, clock, then compare
    task automatic cycle();
        logic [NCH-1:0] nxt;
        bit acc;
        bit in_rng;
        bit tp;
        if (rand_hits) begin
            for (int i = 0; i < NCH; i++) Channels[i] = ($urandom_range(0, 3) == 0);
        end
        acc    = CfgValid && !exp_busy(t);
        in_rng = acc && (int'(CfgChan) < NCH);
        if (in_rng) begin
            ta    = t;
            bchan = int'(CfgChan);
        end
        nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            tp = m_tap(i);
            if (i == bchan && t >= ta && t <= ta + DEPTH) begin
                nxt[i]       = 1'b0;
                last_rise[i] = -1000;
            end else if (m_width[i] == 0) begin
                nxt[i] = tp;
            end else begin
                if (tp && !tprev[i]) last_rise[i] = t;
                nxt[i] = (t - last_rise[i]) < m_width[i];
            end
            tprev[i]   = tp;
            hist[i][t] = Channels[i];
        end
        if (in_rng) begin
            m_delay[bchan] = int'(CfgDelay);
            m_width[bchan] = int'(CfgWidth);
        end
        @(posedge Clk);
        #1;
        t++;
        check("dlay_chann", DlayChann, nxt);
        check("busy", Busy, exp_busy(t));
        check("cfg_ready", CfgReady, !exp_busy(t));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_send(input int ch, input int d, input int w, output int stalls);
        bit done;
        stalls   = 0;
        done     = 1'b0;
        CfgValid = 1'b1;
        CfgChan  = CB'(ch);
        CfgDelay = DB'(d);
        CfgWidth = WB'(w);
        for (int k = 0; k < 64 && !done; k++) begin
            if (CfgReady) done = 1'b1;
            else stalls++;
            cycle();
        end
        CfgValid = 1'b0;
        check("cfg_accepted", done, 1'b1);
    endtask

    task automatic watch(input int ch, input int pattern, input int ncyc, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int k = 0; k < ncyc; k++) begin
            Channels     = '0;
            Channels[ch] = pattern[k];
            cycle();
            if (DlayChann[ch]) begin
                cnt++;
                if (first < 0) first = k + 1;
            end
        end
        Channels = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, first, cnt, bc;
        Rst      = 1'b1;
        Channels = '0;
        CfgValid = 1'b0;
        CfgChan  = '0;
        CfgDelay = '0;
        CfgWidth = '0;
        #1;
        check("in_reset_dlay", DlayChann, 0);
        check("in_reset_busy", Busy, 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        model_reset();
        check("rst_ready", CfgReady, 1);
        check("rst_busy", Busy, 0);
        check("rst_dlay", DlayChann, 0);

        // pass-through default: one cycle of latency
        watch(0, 1, 4, first, cnt);
        check("t1_first", first, 1);
        check("t1_len", cnt, 1);

        // delay 5, no stretch
        cfg_send(1, 5, 0, st);
        check("t2_stalls", st, 0);
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            if (Busy) bc++;
            cycle();
        end
        check("t2_busy_len", bc, DEPTH);
        watch(1, 32'b111, 20, first, cnt);
        check("t2_first", first, 6);
        check("t2_len", cnt, 3);

        // maximum delay with stretch and retrigger
        cfg_send(2, 15, 4, st);
        idle(DEPTH + 1);
        watch(2, 32'b1, 30, first, cnt);
        check("t3_first", first, 16);
        check("t3_len", cnt, 4);
        watch(2, 32'b101, 30, first, cnt);
        check("t3_retrig_first", first, 16);
        check("t3_retrig_len", cnt, 6);

        // second request held through blanking, with traffic on every channel
        rand_hits = 1'b1;
        cfg_send(1, 3, 0, st);
        cfg_send(2, 2, 0, st);
        check("t4_held_stalls", st, DEPTH);
        idle(DEPTH + 4);
        rand_hits = 1'b0;
        Channels  = '0;

        // out-of-range channel
        cfg_send(NCH, 7, 3, st);
        check("t5_stalls", st, 0);
        check("t5_busy", Busy, 0);
        check("t5_ready", CfgReady, 1);
        idle(4);

        // asynchronous reset mid-blank while a stretch is running
        cfg_send(2, 0, 8, st);
        idle(DEPTH + 1);
        Channels[2] = 1'b1;
        cycle();
        Channels = '0;
        idle(2);
        cfg_send(1, 4, 0, st);
        idle(3);
        check("t6_stretch_before", DlayChann[2], 1);
        check("t6_busy_before", Busy, 1);
        #2 Rst = 1'b1;
        #1;
        check("t6_async_dlay", DlayChann, 0);
        check("t6_async_busy", Busy, 0);
        check("t6_async_ready", CfgReady, 1);
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b0;
        model_reset();
        check("t6_rel_ready", CfgReady, 1);
        watch(2, 32'b1, 4, first, cnt);
        check("t6_passthru_first", first, 1);
        check("t6_passthru_len", cnt, 1);

        // randomized traffic and reconfiguration
        rand_hits = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            CfgValid = ($urandom_range(0, 15) == 0);
            CfgChan  = CB'($urandom_range(0, 7));
            CfgDelay = DB'($urandom_range(0, DEPTH - 1));
            CfgWidth = ($urandom_range(0, 3) == 0) ? '0 : WB'($urandom_range(0, 15));
            cycle();
        end
        CfgValid  = 1'b0;
        rand_hits = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_delay_line.md
Name: channel_delay_line

Overview:
Per-channel programmable delay line with optional pulse stretching, feeding the coincidence logic. It is the parametrised successor of the fixed-tap channel delay. Per-channel delay and stretch width are loaded at run time through a valid/ready config port. A channel's output is blanked while its pipeline refills after a reconfiguration.

Parameters:
NCHAN, 4, number of input channels
DEPTH, 16, shift-register length per channel; maximum delay is DEPTH-1 (power of two, >=2)
WBITS, 4, width of the stretch-length field
DBITS, $clog2(DEPTH), derived: delay field width
CBITS, max(1,$clog2(NCHAN)), derived: channel-index width

Ports:
Clk  in  1  system clock; all logic on rising edge
Rst  in  1  reset, asynchronous, active-high
Channels  in  NCHAN  raw channel hit levels, synchronous to Clk
CfgValid  in  1  config request valid
CfgReady  out  1  config port ready; transfer when CfgValid&&CfgReady
CfgChan  in  CBITS  channel index to reconfigure
CfgDelay  in  DBITS  new delay, in cycles
CfgWidth  in  WBITS  new stretch length; 0 = pass-through
DlayChann  out  NCHAN  delayed/stretched channel outputs, registered
Busy  out  1  high while a blanking interval is in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - DlayChann=0 and Busy=0.
  - All shift registers, delay registers, width registers and stretch counters are 0.
  - FSM is IDLE; CfgReady=1 in the first cycle after Rst deasserts.
- Shift register: each cycle sr[i] <= {sr[i][DEPTH-2:0], Channels[i]}.
- Tap: tap[i] = Channels[i] when Delay[i]==0, otherwise sr[i][Delay[i]-1].
- Latency: DlayChann[i] follows Channels[i] by exactly Delay[i]+1 cycles (pass-through mode).
- Stretch, Width[i]!=0:
  - A rising edge of tap[i] loads cnt[i]=Width[i].
  - DlayChann[i] is 1 while cnt[i]!=0; cnt decrements each cycle.
  - Result is a pulse exactly Width[i] cycles long, starting at the same cycle pass-through would rise.
  - A rising edge while cnt!=0 reloads cnt (retrigger, pulse extends).
  - A level held high does not retrigger.
- Stretch, Width[i]==0: DlayChann[i] <= tap[i].
- CfgDelay > DEPTH-1 cannot occur by width; all values are legal. CfgDelay == DEPTH-1 is the maximum.
- FSM states: IDLE, BLANK.
  - IDLE: CfgReady=1. On a transfer with CfgChan<NCHAN:
    - Delay[CfgChan] and Width[CfgChan] are written at the clock edge; cnt[CfgChan] is cleared.
    - Blank counter is loaded with DEPTH; bchan=CfgChan; next state BLANK.
  - IDLE, transfer with CfgChan>=NCHAN: transfer is accepted and ignored; state stays IDLE; CfgReady stays 1.
  - BLANK: CfgReady=0, Busy=1.
    - DlayChann[bchan] forced 0 and its stretch counter held at 0.
    - Counter decrements each cycle; at 1 -> IDLE. Blanking therefore lasts exactly DEPTH cycles after the accept edge.
    - Other channels run unaffected.
- Shift contents are not cleared on reconfiguration, only masked.
- Simultaneous events:
  - A hit arriving on the accept cycle enters the shift register normally.
  - New delay/width apply from the next cycle.
  - CfgValid held during BLANK is not accepted until IDLE.
- Rst asserted mid-BLANK returns everything to reset values immediately. Delays/widths revert to 0.

Decomposition:
- Package delay_line_pkg:
  - cfg_t struct {chan, delay, width}.
  - FSM state enum {IDLE, BLANK}.
  - Helper function for CBITS.
- Sub-module channel_delay_tap, instantiated NCHAN times, containing:
  - one shift register;
  - tap mux;
  - stretch counter;
  - blank mask input.
- The top level holds the config FSM, blank counter and config registers.

Test Plan:
1. Reset, then drive Channels[0] as a 1-cycle pulse -> DlayChann[0] pulses 1 cycle later (Delay=0, Width=0); CfgReady=1, Busy=0.
2. Configure chan 1, Delay=5, Width=0; after blanking, pulse Channels[1] for 3 cycles -> DlayChann[1] high for 3 cycles starting 6 cycles later; Busy high exactly 16 cycles after accept.
3. Configure chan 2, Delay=15, Width=4; 1-cycle pulse -> 4-cycle output starting 16 cycles later. Second pulse 2 cycles after the first -> output extends to 6 cycles total.
4. Hold CfgValid through BLANK with a second request -> accepted on the first IDLE cycle only. Channels 0/3 keep correct delayed output throughout; blanked channel reads 0 even with hits queued.
5. CfgChan=NCHAN (out-of-range) -> accepted in one cycle, no Busy, no register change.
6. Assert Rst during BLANK with stretch active -> all outputs 0 asynchronously. After release, Delay=0 pass-through and CfgReady=1.
